// File: rtl/signed_mul8_arbiter.sv
// Two-requester front end for a shared external signed 8x8 multiplier, with a 2-entry tagged result FIFO.
// Define MULARB_FIXED_PRIO_EN for strict priority (requester 0 wins); default is round-robin.
module signed_mul8_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [WIDTH-1:0]     req0_a,
  input  logic [WIDTH-1:0]     req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [WIDTH-1:0]     req1_a,
  input  logic [WIDTH-1:0]     req1_b,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 res_id,
  output logic [2*WIDTH-1:0]   res_prod,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  input  logic [2*WIDTH-1:0]   mul_out
);

  logic [1:0]          r_count;
  logic                r_wr_ptr;
  logic                r_rd_ptr;
  logic [2*WIDTH-1:0]  r_prod_mem [2];
  logic                r_id_mem   [2];

  logic w_can_push;
  logic w_grant0;
  logic w_grant1;
  logic w_push;
  logic w_pop;

  // Accept depends only on registered occupancy, never on res_ready.
  assign w_can_push = (r_count != 2'd2);

`ifdef MULARB_FIXED_PRIO_EN
  always_comb begin
    w_grant0 = req0_valid;
    w_grant1 = req1_valid & ~req0_valid;
  end
`else
  logic r_last_grant;

  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant0 = r_last_grant;
      w_grant1 = ~r_last_grant;
    end else if (req0_valid) begin
      w_grant0 = 1'b1;
    end else if (req1_valid) begin
      w_grant1 = 1'b1;
    end
  end

  // Reset value 1 hands the first contention to requester 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_last_grant <= 1'b1;
    end else if (w_push) begin
      r_last_grant <= w_grant1;
    end
  end
`endif

  assign req0_ready = w_grant0 & w_can_push & rstn;
  assign req1_ready = w_grant1 & w_can_push & rstn;

  assign w_push = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign w_pop  = res_valid & res_ready;

  assign mul_a = w_grant1 ? req1_a : req0_a;
  assign mul_b = w_grant1 ? req1_b : req0_b;

  assign res_valid = (r_count != 2'd0);
  assign res_id    = r_id_mem[r_rd_ptr];
  assign res_prod  = r_prod_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is cleared on reset so res_id/res_prod read zero afterwards.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2; i++) begin
        r_prod_mem[i] <= '0;
        r_id_mem[i]   <= 1'b0;
      end
    end else if (w_push) begin
      r_prod_mem[r_wr_ptr] <= mul_out;
      r_id_mem[r_wr_ptr]   <= w_grant1;
    end
  end

endmodule

// File: tb/tb_signed_mul8_arbiter.sv
// Scoreboard bench for signed_mul8_arbiter; models the shared multiplier behaviourally.
module tb_signed_mul8_arbiter;

  logic        clk;
  logic        rstn;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;
  logic        res_valid, res_ready, res_id;
  logic [15:0] res_prod;
  logic [7:0]  mul_a, mul_b;
  logic [15:0] mul_out;

  int n_tests = 0;
  int n_fail  = 0;
  logic [16:0] q[$];
  logic acc0, acc1;

  function automatic logic [15:0] smul(input logic [7:0] a, input logic [7:0] b);
    int ia;
    int ib;
    ia = $signed(a);
    ib = $signed(b);
    return 16'(ia * ib);
  endfunction

  assign mul_out = smul(mul_a, mul_b);

  signed_mul8_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_prod(res_prod),
    .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  // Compare pops against queue head, then enqueue this cycle's accepted transfer.
  task automatic sb_sample();
    logic [16:0] e;
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (!rstn) return;
    check("res_valid", {31'd0, res_valid}, {31'd0, q.size() != 0});
    check("accept", {31'd0, req0_ready | req1_ready},
          {31'd0, (req0_valid | req1_valid) && (q.size() < 2)});
    check("one_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
    if (res_valid && res_ready) begin
      if (q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("res_id", {31'd0, res_id}, {31'd0, e[16]});
        check("res_prod", {16'd0, res_prod}, {16'd0, e[15:0]});
        $display("[TB] pop id=%0d prod=%h", res_id, res_prod);
      end
    end
    if (req0_valid && req0_ready) begin
      acc0 = 1'b1;
      q.push_back({1'b0, smul(req0_a, req0_b)});
    end
    if (req1_valid && req1_ready) begin
      acc1 = 1'b1;
      q.push_back({1'b1, smul(req1_a, req1_b)});
    end
  endtask

  task automatic tick();
    sb_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic new_ops();
    if (acc0) begin
      req0_a = 8'($urandom);
      req0_b = 8'($urandom);
    end
    if (acc1) begin
      req1_a = 8'($urandom);
      req1_b = 8'($urandom);
    end
  endtask

  task automatic drain();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready  = 1'b1;
    repeat (4) begin
      settle();
      tick();
    end
    check("drained", {31'd0, res_valid}, 32'd0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    q.delete();
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  int exp_g;
  int prev_g;

  initial begin
    rstn = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_a = 8'd3; req0_b = 8'd4; req1_a = 8'd0; req1_b = 8'd0;
    res_ready = 1'b0;
    #2;
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    check("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
    check("rst_res_id", {31'd0, res_id}, 32'd0);
    check("rst_res_prod", {16'd0, res_prod}, 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    req0_valid = 1'b0;

    // Corner products back-to-back from requester 0.
    res_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 8'h80; req0_b = 8'h80;
    settle();
    check("corner_ready", {31'd0, req0_ready}, 32'd1);
    tick();
    req0_a = 8'h7F; req0_b = 8'h80;
    settle();
    check("corner_p0", {16'd0, res_prod}, 32'h4000);
    check("corner_id0", {31'd0, res_id}, 32'd0);
    tick();
    req0_a = 8'hFF; req0_b = 8'hFF;
    settle();
    check("corner_p1", {16'd0, res_prod}, 32'hC080);
    tick();
    req0_valid = 1'b0;
    settle();
    check("corner_p2", {16'd0, res_prod}, 32'h0001);
    check("corner_v2", {31'd0, res_valid}, 32'd1);
    tick();
    drain();

    // Contention straight after reset.
    do_reset();
    req0_a = 8'($urandom); req0_b = 8'($urandom);
    req1_a = 8'($urandom); req1_b = 8'($urandom);
    req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
    prev_g = 0;
    for (int i = 0; i < 6; i++) begin
`ifdef MULARB_FIXED_PRIO_EN
      exp_g = 0;
`else
      exp_g = i % 2;
`endif
      settle();
      check("grant0", {31'd0, req0_ready}, {31'd0, exp_g == 0});
      check("grant1", {31'd0, req1_ready}, {31'd0, exp_g == 1});
      if (i > 0) check("rr_id", {31'd0, res_id}, prev_g);
      tick();
      new_ops();
      prev_g = exp_g;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    settle();
    check("rr_id_last", {31'd0, res_id}, prev_g);
    tick();
    drain();

    // Backpressure: fill, stall, single pop, delayed push.
    res_ready = 1'b0;
    req0_valid = 1'b1;
    req0_a = 8'($urandom); req0_b = 8'($urandom);
    for (int i = 0; i < 2; i++) begin
      settle();
      check("bp_accept", {31'd0, req0_ready}, 32'd1);
      tick();
      new_ops();
    end
    settle();
    check("bp_full_ready", {31'd0, req0_ready}, 32'd0);
    tick();
    res_ready = 1'b1;
    settle();
    check("bp_pop_noready", {31'd0, req0_ready}, 32'd0);
    tick();
    res_ready = 1'b0;
    settle();
    check("bp_next_accept", {31'd0, req0_ready}, 32'd1);
    tick();
    new_ops();
    settle();
    check("bp_full_again", {31'd0, req0_ready}, 32'd0);
    tick();
    drain();

    // Steady push+pop at occupancy 1 across pointer wrap.
    res_ready = 1'b1;
    req0_valid = 1'b1;
    req0_a = 8'($urandom); req0_b = 8'($urandom);
    for (int i = 0; i < 6; i++) begin
      settle();
      check("pp_ready", {31'd0, req0_ready}, 32'd1);
      if (i > 0) check("pp_valid", {31'd0, res_valid}, 32'd1);
      tick();
      new_ops();
    end
    drain();

    // Reset with two buffered results.
    res_ready = 1'b0;
    req0_valid = 1'b1;
    req0_a = 8'($urandom); req0_b = 8'($urandom);
    repeat (2) begin
      settle();
      tick();
      new_ops();
    end
    settle();
    check("mid_full", {31'd0, res_valid}, 32'd1);
    rstn = 1'b0;
    q.delete();
    #1;
    check("mid_rst_valid", {31'd0, res_valid}, 32'd0);
    check("mid_rst_prod", {16'd0, res_prod}, 32'd0);
    check("mid_rst_ready", {31'd0, req0_ready}, 32'd0);
    req1_valid = 1'b1;
    req1_a = 8'($urandom); req1_b = 8'($urandom);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    res_ready = 1'b1;
    settle();
    check("post_rst_g0", {31'd0, req0_ready}, 32'd1);
    check("post_rst_g1", {31'd0, req1_ready}, 32'd0);
    tick();
    new_ops();
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/signed_mul8_arbiter.md
# signed_mul8_arbiter

Shares one combinational signed 8x8 radix-4 Booth multiplier between two requesters. Arbitration is round-robin per cycle. Results are buffered in a 2-entry result FIFO, and each result is tagged with the requester that issued it. The block sits between the posit FMA front-end request sources and the shared `SignedMultiplier8x8` datapath. It adds one registered stage plus buffering so that backpressure on the result side never reaches the multiplier combinationally.

## Interface
Parameters:
- WIDTH, 8: operand width. Fixed at 8 to match the multiplier; product width is 2*WIDTH = 16.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has operands.
- req0_ready  out  1  requester 0 transfer accepted this cycle.
- req0_a, req0_b  in  8 each  requester 0 signed operands.
- req1_valid, req1_ready, req1_a, req1_b: same as requester 0, for requester 1.
- res_valid  out  1  head FIFO entry is valid.
- res_ready  in  1  consumer takes the head entry.
- res_id  out  1  requester that issued the head entry (0 or 1).
- res_prod  out  16  signed product, two's complement.
- mul_a, mul_b  out  8 each  operands driven to the shared multiplier.
- mul_out  in  16  product returned from the shared multiplier, combinational.

Clock/reset: one clock; reset is asynchronous and active-low, with ports named `clk` and `rstn`.

## Operation
- Accept condition: `can_push = (count != 2)`. It depends only on registered FIFO state and never on `res_ready`.
- Grant, combinational:
  - Only one `reqN_valid` high: grant that requester.
  - Both high: grant the requester that is not `last_grant`.
  - In `_FIXED_PRIO_EN` builds (see Configuration), requester 0 always wins when both are high.
- `reqN_ready = grant_N & can_push`. At most one ready is high in any cycle.
- A transfer occurs when `reqN_valid & reqN_ready`. On a transfer:
  - The granted operands drive `mul_a`/`mul_b`.
  - `{N, mul_out}` is written to the FIFO tail.
  - `last_grant <= N`.
- When no request is valid, `mul_a`/`mul_b` hold requester 0's operands (don't-care). No pointer update and no push.
- Arithmetic: `res_prod = signed(a) * signed(b)`, exact.
  - Range is -16256 to +16384.
  - -128 * -128 = 0x4000 and fits; no saturation or overflow flag.
- FIFO: 2 entries, with `wr_ptr`, `rd_ptr` (1 bit each, wrap 1 -> 0) and `count` (0..2).
  - Pop when `res_valid & res_ready`.
  - `res_valid = (count != 0)`; `res_id`/`res_prod` always show the head entry.
- Simultaneous push and pop:
  - count 1: count stays 1; both pointers advance.
  - count 2: push is blocked because ready was already low; pop proceeds and count becomes 1. A requester that is stalled in that cycle is accepted in the next cycle.
  - count 0: push only. Data is not forwarded combinationally to `res_*`.
- Requests are held, not dropped. A requester that deasserts valid before ready is simply not served; no state changes.

## Timing
- Latency: operands accepted in cycle T give `res_valid` with the product in cycle T+1 when the FIFO was empty.
- Throughput: 1 result/cycle while `res_ready` stays high.
- Reset (asserting `rstn` low):
  - Resets count = 0, `wr_ptr` = `rd_ptr` = 0, `last_grant` = 1, so requester 0 wins the first contention.
  - Outputs during and after reset: `res_valid` = 0, `req0_ready` = `req1_ready` = 0 while `rstn` is low, `res_id` = 0, `res_prod` = 0x0000 (storage cleared).
  - Reset mid-operation discards all buffered results immediately and asynchronously. No result emerges after reset until a new transfer occurs.
- There is no combinational path from `res_ready` to `reqN_ready`. Paths from `reqN_valid` to `reqN_ready` are combinational through the arbiter only.

## Configuration
- `MULARB_FIXED_PRIO_EN`:
  - Defined: strict priority, requester 0 over requester 1. `last_grant` is not implemented, and requester 1 can starve.
  - Undefined (default): round-robin as described in Operation. With both requesters valid continuously and no backpressure, grants alternate 0,1,0,1...

## Test plan
- Corner products: req0 issues (-128,-128), (127,-128) and (-1,-1) back-to-back with `res_ready` = 1. Required: `res_prod` = 0x4000, 0xC080, 0x0001 in consecutive cycles, each with `res_id` = 0.
- Contention: both requesters valid for 6 cycles after reset (round-robin build). Required grants are 0,1,0,1,0,1 and `res_id` follows the same sequence one cycle later.
- Backpressure: hold `res_ready` = 0 with req0 valid.
  - Required: two accepts, then `req0_ready` = 0 while count = 2.
  - Raise `res_ready` for one cycle: one pop, no push that cycle, and the push lands the following cycle.
- Simultaneous push/pop at count 1: count stays 1 and results emerge in order, with no loss or duplication across `wr_ptr` wrap.
- Reset mid-operation: assert `rstn` low with count = 2. Required: `res_valid` drops immediately, and after release the first contention is granted to req0.
- `MULARB_FIXED_PRIO_EN` defined with both requesters valid for 4 cycles: all grants go to req0 and `req1_ready` stays 0.
